// File: rtl/trap_pkg.sv
// Shared definitions for the trapezoid rendering engine: FSM encoding,
// default coordinate widths and the per-edge state record.
package trap_pkg;

  localparam int TRAP_FRAC_BITS = 8;
  localparam int TRAP_Y_W       = 8;
  localparam int TRAP_X_W       = 16;
  localparam int TRAP_X_INT_W   = TRAP_X_W - TRAP_FRAC_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EMIT   = 3'd1,
    ST_STEP_L = 3'd2,
    ST_STEP_R = 3'd3,
    ST_FIN    = 3'd4
  } walk_state_e;

  // One trapezoid edge: current x, step magnitude and step direction.
  typedef struct packed {
    logic [TRAP_X_W-1:0] x;
    logic [TRAP_X_W-1:0] dx;
    logic                neg;
  } edge_t;

endpackage

// File: rtl/trap_edge_walker_if.sv
// Row handshake from the edge walker to the span fill stage.
interface trap_edge_walker_if
  import trap_pkg::*;
#(
  parameter int Y_W     = TRAP_Y_W,
  parameter int X_INT_W = TRAP_X_INT_W
);

  logic               row_valid;
  logic               row_ready;
  logic [Y_W-1:0]     row_y;
  logic [X_INT_W-1:0] row_xl;
  logic [X_INT_W-1:0] row_xr;

  modport master (
    output row_valid, row_y, row_xl, row_xr,
    input  row_ready
  );

  modport slave (
    input  row_valid, row_y, row_xl, row_xr,
    output row_ready
  );

endinterface

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder/subtractor: sum = a + b (cin=0) or a - b (cin=1),
// built from 4-bit lookahead groups with a second lookahead level across groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  // Carries into bits 0..3 of a 4-bit group, fully expanded.
  function automatic logic [3:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                            input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [15:0] b_eff;
  logic [15:0] gen;
  logic [15:0] prop;
  logic [15:0] carry;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_c;

  // Subtraction is two's complement: invert b and feed the 1 in through cin.
  assign b_eff = b ^ {16{cin}};
  assign gen   = a & b_eff;
  assign prop  = a ^ b_eff;

  for (genvar k = 0; k < 4; k++) begin : g_group
    assign grp_g[k]        = group_gen(gen[4*k +: 4], prop[4*k +: 4]);
    assign grp_p[k]        = &prop[4*k +: 4];
    assign carry[4*k +: 4] = lookahead4(gen[4*k +: 4], prop[4*k +: 4], grp_c[k]);
  end

  assign grp_c = lookahead4(grp_g, grp_p, cin);
  assign sum   = prop ^ carry;

endmodule

// File: rtl/trap_edge_walker.sv
// Scanline edge walker: steps both trapezoid edges one row at a time in Q8.8
// and hands (y, floor(xl), floor(xr)) to the span stage, one row per 3 clocks.
module trap_edge_walker
  import trap_pkg::*;
#(
  parameter int FRAC_BITS = TRAP_FRAC_BITS,
  parameter int Y_W       = TRAP_Y_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [Y_W-1:0]      y_top,
  input  logic [Y_W-1:0]      y_bot,
  input  logic [TRAP_X_W-1:0] xl0,
  input  logic [TRAP_X_W-1:0] xr0,
  input  logic [TRAP_X_W-1:0] dxl,
  input  logic                dxl_neg,
  input  logic [TRAP_X_W-1:0] dxr,
  input  logic                dxr_neg,
  trap_edge_walker_if.master  row,
  output logic                busy,
  output logic                done
);

  walk_state_e    state_q, state_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W-1:0] y_bot_q, y_bot_d;
  edge_t          edge_l_q, edge_l_d;
  edge_t          edge_r_q, edge_r_d;

  logic                step_r;
  logic [TRAP_X_W-1:0] cla_a;
  logic [TRAP_X_W-1:0] cla_b;
  logic                cla_cin;
  logic [TRAP_X_W-1:0] cla_sum;

  // The single adder serves the left edge in STEP_L and the right edge in STEP_R.
  assign step_r  = (state_q == ST_STEP_R);
  assign cla_a   = step_r ? edge_r_q.x   : edge_l_q.x;
  assign cla_b   = step_r ? edge_r_q.dx  : edge_l_q.dx;
  assign cla_cin = step_r ? edge_r_q.neg : edge_l_q.neg;

  cla16 u_cla16 (
    .a   (cla_a),
    .b   (cla_b),
    .cin (cla_cin),
    .sum (cla_sum)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    y_d      = y_q;
    y_bot_d  = y_bot_q;
    edge_l_d = edge_l_q;
    edge_r_d = edge_r_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (y_bot >= y_top) begin
            y_d      = y_top;
            y_bot_d  = y_bot;
            edge_l_d = '{x: xl0, dx: dxl, neg: dxl_neg};
            edge_r_d = '{x: xr0, dx: dxr, neg: dxr_neg};
            state_d  = ST_EMIT;
          end else begin
            state_d  = ST_FIN;
          end
        end
      end
      ST_EMIT: begin
        if (row.row_ready) begin
          state_d = (y_q == y_bot_q) ? ST_FIN : ST_STEP_L;
        end
      end
      ST_STEP_L: begin
        edge_l_d.x = cla_sum;
        state_d    = ST_STEP_R;
      end
      ST_STEP_R: begin
        edge_r_d.x = cla_sum;
        y_d        = y_q + 1'b1;
        state_d    = ST_EMIT;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the FSM so the row
  // outputs read as zero while reset is held, not whatever was left behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      y_q      <= '0;
      y_bot_q  <= '0;
      edge_l_q <= '0;
      edge_r_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      y_q      <= y_d;
      y_bot_q  <= y_bot_d;
      edge_l_q <= edge_l_d;
      edge_r_q <= edge_r_d;
    end
  end

  assign row.row_valid = (state_q == ST_EMIT);
  assign row.row_y     = y_q;
  assign row.row_xl    = edge_l_q.x[TRAP_X_W-1:FRAC_BITS];
  assign row.row_xr    = edge_r_q.x[TRAP_X_W-1:FRAC_BITS];
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FIN);

endmodule

// File: tb/tb_trap_edge_walker.sv
// Directed bench for trap_edge_walker: a row model fills a scoreboard queue when a
// descriptor is issued; rows are popped and compared as the walker presents them.
module tb_trap_edge_walker;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  y_top, y_bot;
  logic [15:0] xl0, xr0, dxl, dxr;
  logic        dxl_neg, dxr_neg;
  logic        busy, done;

  trap_edge_walker_if row_if ();

  trap_edge_walker dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .y_top   (y_top),
    .y_bot   (y_bot),
    .xl0     (xl0),
    .xr0     (xr0),
    .dxl     (dxl),
    .dxl_neg (dxl_neg),
    .dxr     (dxr),
    .dxr_neg (dxr_neg),
    .row     (row_if.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [7:0] xl;
    logic [7:0] xr;
  } row_t;

  row_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_row(input logic [7:0] y, input logic [7:0] xl, input logic [7:0] xr);
    exp_q.push_back('{y, xl, xr});
  endtask

  // Reference walk: plain 16-bit modulo stepping, integer part is the top byte.
  task automatic push_model(input logic [7:0] yt, input logic [7:0] yb,
                            input logic [15:0] l0, input logic [15:0] dl, input logic nl,
                            input logic [15:0] r0, input logic [15:0] dr, input logic nr);
    logic [15:0] l;
    logic [15:0] r;
    l = l0;
    r = r0;
    for (int y = int'(yt); y <= int'(yb); y++) begin
      push_row(8'(y), l[15:8], r[15:8]);
      l = nl ? l - dl : l + dl;
      r = nr ? r - dr : r + dr;
    end
  endtask

  // Issues start for one clock; returns on the negedge one clock after the start edge.
  task automatic start_job(input logic [7:0] yt, input logic [7:0] yb,
                           input logic [15:0] l0, input logic [15:0] dl, input logic nl,
                           input logic [15:0] r0, input logic [15:0] dr, input logic nr);
    @(negedge clk);
    y_top = yt; y_bot = yb;
    xl0 = l0; dxl = dl; dxl_neg = nl;
    xr0 = r0; dxr = dr; dxr_neg = nr;
    start = 1'b1;
    acc_q.delete();
    @(negedge clk);
    start = 1'b0;
    y_top = 8'($urandom); y_bot = 8'($urandom);
    xl0 = 16'($urandom); xr0 = 16'($urandom);
    dxl = 16'($urandom); dxr = 16'($urandom);
  endtask

  // Drains rows until done. Cycle 1 is the first negedge after the start edge; an
  // accept is logged with the cycle whose following posedge completes it.
  task automatic collect(input int stall_y, input int stall_n, input int poke_y,
                         output int done_cyc);
    row_t e;
    int   cyc;
    int   stalled;
    bit   holding;
    bit   poked;
    bit   fin;
    cyc = 1; stalled = 0; holding = 0; poked = 0; fin = 0; done_cyc = -1;
    for (int i = 0; i < 200 && !fin; i++) begin
      start = 1'b0;
      check("done_valid_exclusive", 32'(done & row_if.row_valid), 0);
      if (holding) check("valid_held_under_backpressure", 32'(row_if.row_valid), 1);
      holding = 0;
      if (done) begin
        done_cyc = cyc;
        fin = 1;
      end else begin
        row_if.row_ready = 1'b1;
        if (row_if.row_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_row", 32'(row_if.row_valid), 0);
          end else begin
            e = exp_q[0];
            check("row_y",  32'(row_if.row_y),  32'(e.y));
            check("row_xl", 32'(row_if.row_xl), 32'(e.xl));
            check("row_xr", 32'(row_if.row_xr), 32'(e.xr));
            if (int'(row_if.row_y) == stall_y && stalled < stall_n) begin
              row_if.row_ready = 1'b0;
              stalled++;
              holding = 1;
            end else begin
              void'(exp_q.pop_front());
              acc_q.push_back(cyc);
            end
            if (int'(row_if.row_y) == poke_y && !poked) begin
              poked = 1;
              start = 1'b1;
              y_top = 8'd0; y_bot = 8'hFF;
              xl0 = 16'h7777; dxl = 16'h0303; xr0 = 16'h1111; dxr = 16'h0505;
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("collect_reached_done", 32'(fin), 1);
    if (fin) begin
      check("rows_left_in_scoreboard", 32'(exp_q.size()), 0);
      @(negedge clk);
      check("done_single_cycle", 32'(done), 0);
      check("idle_after_done", 32'(busy), 0);
    end
  endtask

  task automatic check_timing(input string tag, input int a0, input int a1, input int a2,
                              input int n, input int dc_obs, input int dc_exp);
    check({tag, "_accepts"}, 32'(acc_q.size()), 32'(n));
    if (n > 0 && acc_q.size() > 0) check({tag, "_accept0"}, 32'(acc_q[0]), 32'(a0));
    if (n > 1 && acc_q.size() > 1) check({tag, "_accept1"}, 32'(acc_q[1]), 32'(a1));
    if (n > 2 && acc_q.size() > 2) check({tag, "_accept2"}, 32'(acc_q[2]), 32'(a2));
    check({tag, "_done_cycle"}, 32'(dc_obs), 32'(dc_exp));
  endtask

  task automatic push_basic_rows();
    push_row(8'd10, 8'd10, 8'd20);
    push_row(8'd11, 8'd9,  8'd21);
    push_row(8'd12, 8'd9,  8'd22);
  endtask

  task automatic start_basic();
    start_job(8'd10, 8'd12, 16'h0A00, 16'h0080, 1'b1, 16'h1400, 16'h0100, 1'b0);
  endtask

  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; row_if.row_ready = 1'b1;
    y_top = '0; y_bot = '0; xl0 = '0; xr0 = '0; dxl = '0; dxr = '0;
    dxl_neg = 1'b0; dxr_neg = 1'b0;
    #1;
    check("reset_row_valid", 32'(row_if.row_valid), 0);
    check("reset_busy",      32'(busy), 0);
    check("reset_done",      32'(done), 0);
    check("reset_row_y",     32'(row_if.row_y), 0);
    check("reset_row_xl",    32'(row_if.row_xl), 0);
    check("reset_row_xr",    32'(row_if.row_xr), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic case.
    push_basic_rows();
    start_basic();
    check("basic_first_valid", 32'(row_if.row_valid), 1);
    check("basic_busy", 32'(busy), 1);
    collect(-1, 0, -1, dc);
    check_timing("basic", 1, 4, 7, 3, dc, 8);

    // Backpressure on row 11 for 5 cycles.
    push_basic_rows();
    start_basic();
    collect(11, 5, -1, dc);
    check_timing("backpressure", 1, 9, 12, 3, dc, 13);

    // Single row.
    push_model(8'd7, 8'd7, 16'h0312, 16'h0040, 1'b0, 16'h0580, 16'h0100, 1'b1);
    start_job(8'd7, 8'd7, 16'h0312, 16'h0040, 1'b0, 16'h0580, 16'h0100, 1'b1);
    collect(-1, 0, -1, dc);
    check_timing("single", 1, 0, 0, 1, dc, 2);

    // Empty trapezoid: no row, done right after start.
    push_model(8'd5, 8'd4, 16'h0100, 16'h0100, 1'b0, 16'h0200, 16'h0100, 1'b0);
    start_job(8'd5, 8'd4, 16'h0100, 16'h0100, 1'b0, 16'h0200, 16'h0100, 1'b0);
    check("empty_no_valid", 32'(row_if.row_valid), 0);
    collect(-1, 0, -1, dc);
    check_timing("empty", 0, 0, 0, 0, dc, 1);

    // Left edge wraps below zero: 0x0040 - 0x0080 = 0xFFC0.
    push_row(8'd0, 8'h00, 8'h10);
    push_row(8'd1, 8'hFF, 8'h10);
    start_job(8'd0, 8'd1, 16'h0040, 16'h0080, 1'b1, 16'h1000, 16'h0000, 1'b0);
    collect(-1, 0, -1, dc);
    check_timing("wrap", 1, 4, 0, 2, dc, 5);

    // Right edge wraps above 0xFFFF while the left edge runs down several rows.
    push_model(8'd200, 8'd203, 16'h8000, 16'h1234, 1'b1, 16'hFE00, 16'h00C0, 1'b0);
    start_job(8'd200, 8'd203, 16'h8000, 16'h1234, 1'b1, 16'hFE00, 16'h00C0, 1'b0);
    collect(-1, 0, -1, dc);
    check_timing("wrap_up", 1, 4, 7, 4, dc, 11);

    // Reset while a row is held under backpressure.
    push_basic_rows();
    start_basic();
    check("rst_pre_valid", 32'(row_if.row_valid), 1);
    row_if.row_ready = 1'b0;
    @(negedge clk);
    check("rst_pre_valid_held", 32'(row_if.row_valid), 1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_row_valid", 32'(row_if.row_valid), 0);
    check("rst_async_busy",      32'(busy), 0);
    check("rst_async_done",      32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    row_if.row_ready = 1'b1;
    exp_q.delete();
    check("rst_idle_after_release", 32'(busy), 0);
    push_basic_rows();
    start_basic();
    collect(-1, 0, -1, dc);
    check_timing("after_reset", 1, 4, 7, 3, dc, 8);

    // A start pulse during row 11 must change nothing.
    push_basic_rows();
    start_basic();
    collect(-1, 0, 11, dc);
    check_timing("start_ignored", 1, 4, 7, 3, dc, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
